regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter XLEN, default 64, register data width.
REQ-002 Parameter NREG, default 32, number of architectural registers; address width 5.
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, reset: synchronous and active-low.
REQ-005 Ports a_valid in 1, a_ready out 1, a_rd in 5, a_data in XLEN: ALU writeback requester.
REQ-006 Ports b_valid in 1, b_ready out 1, b_rd in 5, b_data in XLEN: load (memory) writeback requester.
REQ-007 Ports RegWrite out 1, writereg out 5, writedata out XLEN: drive the register file write port directly.
REQ-008 Ports rsv_valid in 1, rsv_rd in 5: destination reservation from issue.
REQ-009 Ports qry_rs1 in 5, qry_rs2 in 5, busy1 out 1, busy2 out 1: hazard query for the register file read addresses.

Function
REQ-010 Transfer on a requester occurs in a cycle where valid and ready are both high; at most one transfer per cycle.
REQ-011 Ready is combinational from the valid inputs and the arbitration pointer: only one valid -> that side ready; both valid -> side selected by pointer ready, other not ready; neither valid -> both ready low.
REQ-012 Requester holds valid, rd and data stable until ready; the block does not buffer a losing request.
REQ-013 Round-robin pointer: 0 favours A, 1 favours B; it changes only in conflict cycles (both valid), pointing to the loser after the edge.
REQ-014 Accepted write appears on writereg/writedata with RegWrite=1 exactly one cycle after the transfer edge (registered, latency 1); RegWrite is a one-cycle pulse per transfer.
REQ-015 No transfer in a cycle -> RegWrite=0 next cycle; writereg/writedata keep their last values.
REQ-016 Transfer with rd=0 is accepted (ready per REQ-011) but produces RegWrite=0 and does not touch the scoreboard.
REQ-017 Scoreboard: one busy bit per register 1..NREG-1; bit 0 is constant 0.
REQ-018 rsv_valid=1 with rsv_rd!=0 sets busy[rsv_rd] at the edge; reserving an already-busy register leaves it busy (no count).
REQ-019 A transfer with rd!=0 clears busy[rd] at the transfer edge.
REQ-020 Same-edge reservation and clear of the same register: set wins, bit stays 1.
REQ-021 busy1=busy[qry_rs1], busy2=busy[qry_rs2], combinational from scoreboard state only (no bypass of the current-cycle transfer).

Reset
REQ-022 rst_n=0 at an edge: RegWrite=0, writereg=0, writedata=0, pointer=0, all busy bits 0.
REQ-023 While rst_n=0, a_ready=b_ready=0 and rsv_valid is ignored; a request pending when reset asserts is dropped, and the requester must re-present it.
REQ-024 First cycle after rst_n returns high: normal arbitration with pointer=0.

Structure
REQ-025 Shared package regfile_pkg holds XLEN, NREG, register address width and the constant for register 0; the register file block imports the same package.
REQ-026 A single sub-module rr_arb2 (2-way round-robin arbiter: valids in, grants out, pointer state) is instantiated once; the scoreboard and output register live in the top.

Verification
REQ-027 a_valid only, a_rd=5, a_data=0x20 -> a_ready=1; next cycle RegWrite=1, writereg=5, writedata=0x20; following cycle RegWrite=0.
REQ-028 Both valid for 3 cycles from reset (a_rd=1, b_rd=2) -> grants A, B, A in order; RegWrite pulses with writereg 1, 2, 1.
REQ-029 b_valid with b_rd=0, b_data=0xFFFF -> b_ready=1, RegWrite stays 0, scoreboard unchanged.
REQ-030 rsv_rd=7, then qry_rs1=7 -> busy1=1; a write to rd=7 accepted -> busy1=0 the cycle after the edge; reservation of 7 together with a write to 7 on the same edge -> busy1 stays 1.
REQ-031 rst_n=0 for one edge while a_valid=1 and busy[3]=1 -> a_ready=0, RegWrite=0, busy[3]=0, pointer=0 after that edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback path.
// The register file block imports this same package so widths stay in step.
package regfile_pkg;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef enum logic {
    PTR_A = 1'b0,
    PTR_B = 1'b1
  } rr_ptr_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback requesters, register-file write port, reservation and hazard query.
// The slave modport is the arbiter's view; master is the surrounding pipeline.
interface regfile_wb_arbiter_if #(
  parameter int XLEN = regfile_pkg::XLEN
);
  import regfile_pkg::*;

  logic              a_valid;
  logic              a_ready;
  logic [REG_AW-1:0] a_rd;
  logic [XLEN-1:0]   a_data;

  logic              b_valid;
  logic              b_ready;
  logic [REG_AW-1:0] b_rd;
  logic [XLEN-1:0]   b_data;

  logic              RegWrite;
  logic [REG_AW-1:0] writereg;
  logic [XLEN-1:0]   writedata;

  logic              rsv_valid;
  logic [REG_AW-1:0] rsv_rd;

  logic [REG_AW-1:0] qry_rs1;
  logic [REG_AW-1:0] qry_rs2;
  logic              busy1;
  logic              busy2;

  modport slave (
    input  a_valid, a_rd, a_data,
    input  b_valid, b_rd, b_data,
    input  rsv_valid, rsv_rd, qry_rs1, qry_rs2,
    output a_ready, b_ready,
    output RegWrite, writereg, writedata,
    output busy1, busy2
  );

  modport master (
    output a_valid, a_rd, a_data,
    output b_valid, b_rd, b_data,
    output rsv_valid, rsv_rd, qry_rs1, qry_rs2,
    input  a_ready, b_ready,
    input  RegWrite, writereg, writedata,
    input  busy1, busy2
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer only moves on a conflict, and then
// it points at the loser so that side wins the next conflict.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  rr_ptr_t ptr, ptr_next;

  always_ff @(posedge clk) begin
    if (!rst_n) ptr <= PTR_A;
    else        ptr <= ptr_next;
  end

  // Grants are withheld during reset so a pending request is dropped, not taken.
  always_comb begin
    gnt      = 2'b00;
    ptr_next = ptr;
    if (rst_n) begin
      unique case (req)
        2'b01: gnt = 2'b01;
        2'b10: gnt = 2'b10;
        2'b11: begin
          if (ptr == PTR_A) begin
            gnt      = 2'b01;
            ptr_next = PTR_B;
          end else begin
            gnt      = 2'b10;
            ptr_next = PTR_A;
          end
        end
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto the single register-file write port
// and tracks outstanding destination registers for hazard detection.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int XLEN = regfile_pkg::XLEN,
  parameter int NREG = regfile_pkg::NREG
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  wb
);

  logic [1:0]        gnt;
  logic              xfer;
  logic              wr_en;
  logic [REG_AW-1:0] xfer_rd;
  logic [XLEN-1:0]   xfer_data;
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_next;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({wb.b_valid, wb.a_valid}),
    .gnt   (gnt)
  );

  assign wb.a_ready = gnt[0];
  assign wb.b_ready = gnt[1];

  always_comb begin
    xfer      = |gnt;
    xfer_rd   = gnt[1] ? wb.b_rd   : wb.a_rd;
    xfer_data = gnt[1] ? wb.b_data : wb.a_data;
    wr_en     = xfer && (xfer_rd != REG_ZERO);
  end

  // Writes to x0 are accepted but never reach the port, so the last real write is held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb.RegWrite  <= 1'b0;
      wb.writereg  <= '0;
      wb.writedata <= '0;
    end else begin
      wb.RegWrite <= wr_en;
      if (wr_en) begin
        wb.writereg  <= xfer_rd;
        wb.writedata <= xfer_data;
      end
    end
  end

  // Set is applied after clear so a same-edge reservation keeps the register busy.
  always_comb begin
    busy_next = busy;
    if (wr_en) busy_next[xfer_rd] = 1'b0;
    if (wb.rsv_valid && (wb.rsv_rd != REG_ZERO)) busy_next[wb.rsv_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

  assign wb.busy1 = busy[wb.qry_rs1];
  assign wb.busy2 = busy[wb.qry_rs2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and random checks of the writeback arbiter against a small model
// of the pointer, the busy scoreboard and a queue of expected register writes.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.XLEN(XLEN)) bus ();

  regfile_wb_arbiter #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (bus)
  );

  wr_t               exp_q[$];
  int                checks = 0;
  int                errors = 0;
  logic              mptr;
  logic [NREG-1:0]   mbusy;
  logic [REG_AW-1:0] last_rd;
  logic [XLEN-1:0]   last_data;
  bit                hold_ok;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compares outputs for the current cycle, then advances the model across the coming edge.
  task automatic checkOutput(input logic rstn);
    logic              ea, eb;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
    wr_t               w;
    ea = 1'b0;
    eb = 1'b0;
    if (rstn) begin
      if (bus.a_valid && !bus.b_valid)      ea = 1'b1;
      else if (bus.b_valid && !bus.a_valid) eb = 1'b1;
      else if (bus.a_valid && bus.b_valid) begin
        if (mptr) eb = 1'b1;
        else      ea = 1'b1;
      end
    end
    chk("a_ready", {63'd0, bus.a_ready}, {63'd0, ea});
    chk("b_ready", {63'd0, bus.b_ready}, {63'd0, eb});

    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      chk("RegWrite", {63'd0, bus.RegWrite}, 64'd1);
      chk("writereg", {59'd0, bus.writereg}, {59'd0, w.rd});
      chk("writedata", bus.writedata, w.data);
      last_rd   = w.rd;
      last_data = w.data;
      hold_ok   = 1'b1;
    end else begin
      chk("RegWrite_idle", {63'd0, bus.RegWrite}, 64'd0);
      if (hold_ok) begin
        chk("writereg_hold", {59'd0, bus.writereg}, {59'd0, last_rd});
        chk("writedata_hold", bus.writedata, last_data);
      end
    end

    chk("busy1", {63'd0, bus.busy1}, {63'd0, mbusy[bus.qry_rs1]});
    chk("busy2", {63'd0, bus.busy2}, {63'd0, mbusy[bus.qry_rs2]});

    if (!rstn) begin
      mptr      = 1'b0;
      mbusy     = '0;
      last_rd   = '0;
      last_data = '0;
      hold_ok   = 1'b1;
      exp_q.delete();
    end else begin
      if (bus.a_valid && bus.b_valid) mptr = ~mptr;
      if (ea || eb) begin
        rd   = ea ? bus.a_rd   : bus.b_rd;
        data = ea ? bus.a_data : bus.b_data;
        if (rd != REG_ZERO) begin
          exp_q.push_back({rd, data});
          mbusy[rd] = 1'b0;
        end else begin
          hold_ok = 1'b0;
        end
      end
      if (bus.rsv_valid && bus.rsv_rd != REG_ZERO) mbusy[bus.rsv_rd] = 1'b1;
    end
  endtask

  task automatic applyStimulus(
    input logic rstn,
    input logic av, input logic [REG_AW-1:0] ard, input logic [XLEN-1:0] adata,
    input logic bv, input logic [REG_AW-1:0] brd, input logic [XLEN-1:0] bdata,
    input logic rv, input logic [REG_AW-1:0] rrd,
    input logic [REG_AW-1:0] q1, input logic [REG_AW-1:0] q2
  );
    @(negedge clk);
    rst_n         = rstn;
    bus.a_valid   = av;
    bus.a_rd      = ard;
    bus.a_data    = adata;
    bus.b_valid   = bv;
    bus.b_rd      = brd;
    bus.b_data    = bdata;
    bus.rsv_valid = rv;
    bus.rsv_rd    = rrd;
    bus.qry_rs1   = q1;
    bus.qry_rs2   = q2;
    #1;
    checkOutput(rstn);
  endtask

  task automatic idle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    bus.a_valid   = 1'b0;
    bus.a_rd      = '0;
    bus.a_data    = '0;
    bus.b_valid   = 1'b0;
    bus.b_rd      = '0;
    bus.b_data    = '0;
    bus.rsv_valid = 1'b0;
    bus.rsv_rd    = '0;
    bus.qry_rs1   = '0;
    bus.qry_rs2   = '0;
    mptr          = 1'b0;
    mbusy         = '0;
    last_rd       = '0;
    last_data     = '0;
    hold_ok       = 1'b1;
    @(posedge clk);

    $display("[TB] reset state");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 5);

    $display("[TB] single ALU write");
    applyStimulus(1, 1, 5, 64'h20, 0, 0, 0, 0, 0, 5, 0);
    idle();
    idle();

    $display("[TB] round-robin from reset");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 64'hA1, 1, 2, 64'hB2, 0, 0, 1, 2);
    applyStimulus(1, 1, 1, 64'hA1, 1, 2, 64'hB2, 0, 0, 1, 2);
    applyStimulus(1, 1, 1, 64'hA1, 1, 2, 64'hB2, 0, 0, 1, 2);
    idle();
    idle();

    $display("[TB] load write to x0");
    applyStimulus(1, 0, 0, 0, 1, 0, 64'hFFFF, 0, 0, 0, 0);
    idle();
    idle();

    $display("[TB] scoreboard set, clear, set-wins");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    applyStimulus(1, 1, 7, 64'h77, 0, 0, 0, 0, 0, 7, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    applyStimulus(1, 1, 7, 64'h78, 0, 0, 0, 1, 7, 7, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 7);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    applyStimulus(1, 0, 0, 0, 1, 7, 64'h79, 0, 0, 7, 0);
    idle();

    $display("[TB] reset with pending request");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 3, 3, 0);
    applyStimulus(1, 1, 1, 64'h11, 1, 2, 64'h22, 0, 0, 3, 0);
    applyStimulus(0, 1, 4, 64'h44, 0, 0, 0, 1, 6, 3, 6);
    applyStimulus(1, 1, 4, 64'h44, 1, 9, 64'h99, 0, 0, 3, 6);
    idle();
    idle();

    $display("[TB] random traffic");
    for (int i = 0; i < 200; i++) begin
      applyStimulus(($urandom_range(0, 24) != 0),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom},
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom},
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
    end
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
